// File: rtl/huffman_stream_feeder_if.sv
// Bundle between the Huffman stream feeder and its upstream source, table decoder and symbol sink.
// Carries the stream command, the encoded-word handshake, the decoder exchange, the symbol handshake and status.
interface huffman_stream_feeder_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic [15:0]       cfg_nbits;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [5:0]        dec_window;
  logic              dec_load;
  logic              dec_ready;
  logic [3:0]        dec_symbol;
  logic [3:0]        dec_len;
  logic              sym_valid;
  logic              sym_ready;
  logic [3:0]        sym_data;
  logic [3:0]        sym_len;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, cfg_nbits, in_valid, in_data, dec_ready, dec_symbol, dec_len, sym_ready,
    output in_ready, dec_window, dec_load, sym_valid, sym_data, sym_len, busy, done, err
  );

  modport master (
    output start, cfg_nbits, in_valid, in_data, dec_ready, dec_symbol, dec_len, sym_ready,
    input  in_ready, dec_window, dec_load, sym_valid, sym_data, sym_len, busy, done, err
  );
endinterface

// File: rtl/huffman_stream_feeder.sv
// Feeds MSB-first encoded words through a bit buffer to a table decoder; dec_load 1 cycle after LOAD, sym_valid 1 cycle after dec_ready.
// Upstream stalls while the buffer lacks a free word slot; sym_valid holds with no new dec_load until sym_ready.
module huffman_stream_feeder #(
  parameter int WORD_W = 16,
  parameter int BUF_W  = 32
) (
  input logic                    clk,
  input logic                    rst,
  huffman_stream_feeder_if.slave bus
);
  localparam int CW = $clog2(BUF_W + 1);

  typedef enum logic [2:0] {IDLE, FILL, LOAD, WAIT, EMIT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [BUF_W-1:0]  bit_buf;
  logic [BUF_W-1:0]  buf_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic [16:0]       fetched;
  logic [16:0]       left;
  logic [15:0]       nbits;
  logic [15:0]       remain;
  logic [5:0]        window;
  logic              load_q;
  logic              sym_valid_q;
  logic [3:0]        sym_data_q;
  logic [3:0]        sym_len_q;
  logic              done_q;
  logic              err_q;
  logic              busy;
  logic              in_ready;
  logic              accept;
  logic              consume;
  logic              len_bad;
  logic              start_ok;
  logic [CW-1:0]     take;
  logic [WORD_W-1:0] mask;
  logic [BUF_W-1:0]  ext;
  logic [3:0]        cons_len;

  assign busy     = (state == FILL) || (state == LOAD) || (state == WAIT) || (state == EMIT);
  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
  assign left     = {1'b0, nbits} - fetched;
  assign in_ready = busy && (cnt <= CW'(BUF_W - WORD_W)) && (fetched < {1'b0, nbits});
  assign accept   = bus.in_valid && in_ready;
  assign consume  = (state == EMIT) && bus.sym_ready;
  assign cons_len = consume ? sym_len_q : 4'd0;
  assign len_bad  = (bus.dec_len == 4'd0) || (bus.dec_len > 4'd6) || ({12'd0, bus.dec_len} > remain);

  // Bits past the end of the stream are zeroed on entry, so the window needs no padding logic.
  assign take     = (left >= 17'(WORD_W)) ? CW'(WORD_W) : CW'(left);
  assign mask     = ~({WORD_W{1'b1}} >> take);
  assign ext      = {bus.in_data & mask, {(BUF_W - WORD_W){1'b0}}};

  // Append lands below the pre-shift count, then the consumed code is shifted out.
  assign buf_next = (bit_buf | (accept ? (ext >> cnt) : '0)) << cons_len;
  assign cnt_next = cnt + (accept ? take : '0) - CW'(cons_len);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = (bus.cfg_nbits == 16'd0) ? DONE : FILL;
      FILL:       if ((cnt >= CW'(6)) || ((fetched >= {1'b0, nbits}) && (cnt != '0))) state_next = LOAD;
      LOAD:       state_next = WAIT;
      WAIT:       if (bus.dec_ready) state_next = len_bad ? DONE : EMIT;
      EMIT:       if (bus.sym_ready) state_next = (remain == {12'd0, sym_len_q}) ? DONE : FILL;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_buf     <= '0;
      cnt         <= '0;
      fetched     <= '0;
      nbits       <= '0;
      remain      <= '0;
      window      <= '0;
      load_q      <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_len_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_buf <= '0;
        cnt     <= '0;
        fetched <= '0;
        nbits   <= bus.cfg_nbits;
        remain  <= bus.cfg_nbits;
        done_q  <= (bus.cfg_nbits == 16'd0);
        err_q   <= 1'b0;
      end else begin
        bit_buf <= buf_next;
        cnt     <= cnt_next;
        if (accept)  fetched <= fetched + 17'(WORD_W);
        if (consume) remain  <= remain - {12'd0, sym_len_q};
        if ((state == WAIT) && bus.dec_ready) begin
          if (len_bad) begin
            err_q <= 1'b1;
          end else begin
            sym_data_q <= bus.dec_symbol;
            sym_len_q  <= bus.dec_len;
          end
        end
        if ((state == EMIT) && (state_next == DONE)) done_q <= 1'b1;
      end
      load_q      <= (state_next == LOAD);
      sym_valid_q <= (state_next == EMIT);
      if (state_next == LOAD) window <= buf_next[BUF_W-1 -: 6];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.dec_window = window;
  assign bus.dec_load   = load_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.sym_data   = sym_data_q;
  assign bus.sym_len    = sym_len_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_huffman_stream_feeder.sv
// Directed bench for huffman_stream_feeder: scripted decoder responses, windows predicted from the raw stream bits.
module tb_huffman_stream_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huffman_stream_feeder_if #(.WORD_W(16)) bus ();
  huffman_stream_feeder #(.WORD_W(16), .BUF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;

  logic [15:0] words [4];
  int          nwords;
  int          fed;
  logic [3:0]  scr_sym [8];
  logic [3:0]  scr_len [8];
  int          nsym;
  int          stall_idx;

  function automatic logic [5:0] ref_window(input logic [63:0] s, input int n, input int p);
    logic [63:0] t;
    logic [5:0]  w;
    t = s << p;
    w = t[63:58];
    for (int i = 0; i < 6; i++) if (p + i >= n) w[5-i] = 1'b0;
    return w;
  endfunction

  task automatic do_start(input logic [15:0] n);
    bus.start = 1'b1;
    bus.cfg_nbits = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feeder();
    int acc = 0;
    int b = 0;
    while (acc < nwords && b < 400) begin
      bus.in_valid = 1'b1;
      bus.in_data = words[acc];
      if (bus.in_ready) acc++;
      @(negedge clk);
      b++;
    end
    bus.in_valid = 1'b0;
    fed = acc;
  endtask

  task automatic run_decoder(input logic [63:0] s, input int n);
    int pos = 0;
    int b;
    for (int i = 0; i < nsym; i++) begin
      b = 0;
      while (bus.dec_load !== 1'b1 && b < 300) begin
        @(negedge clk);
        b++;
      end
      checks++;
      if (bus.dec_load !== 1'b1) begin
        $display("FAIL dec_load_timeout sym %0d: dec_load=%b required 1", i, bus.dec_load);
        return;
      end else passed++;
      checks++;
      if (bus.dec_window !== ref_window(s, n, pos))
        $display("FAIL dec_window sym %0d: got %b required %b", i, bus.dec_window, ref_window(s, n, pos));
      else passed++;
      @(negedge clk);
      checks++;
      if (bus.dec_load !== 1'b0) $display("FAIL dec_load_pulse sym %0d: got %b required 0", i, bus.dec_load);
      else passed++;
      bus.dec_ready = 1'b1;
      bus.dec_symbol = scr_sym[i];
      bus.dec_len = scr_len[i];
      @(negedge clk);
      bus.dec_ready = 1'b0;
      checks++;
      if ({bus.sym_valid, bus.sym_data, bus.sym_len} !== {1'b1, scr_sym[i], scr_len[i]})
        $display("FAIL sym_out sym %0d: got v=%b d=%0d l=%0d required v=1 d=%0d l=%0d",
                 i, bus.sym_valid, bus.sym_data, bus.sym_len, scr_sym[i], scr_len[i]);
      else passed++;
      if (i == stall_idx) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if ({bus.sym_valid, bus.dec_load} !== 2'b10)
            $display("FAIL stall_hold cycle %0d: sym_valid=%b dec_load=%b required 1/0", k, bus.sym_valid, bus.dec_load);
          else passed++;
        end
      end
      bus.sym_ready = 1'b1;
      @(negedge clk);
      bus.sym_ready = 1'b0;
      checks++;
      if (bus.sym_valid !== 1'b0) $display("FAIL sym_valid_drop sym %0d: got %b required 0", i, bus.sym_valid);
      else passed++;
      pos += int'(scr_len[i]);
    end
  endtask

  task automatic check_end_ok(input string name);
    int b = 0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && b < 100) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b100)
      $display("FAIL %s_end: done=%b err=%b busy=%b required 1/0/0", name, bus.done, bus.err, bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.dec_load, bus.sym_valid, bus.busy, bus.done, bus.err} !== 6'b0)
      $display("FAIL reset_flags: rdy=%b load=%b sv=%b busy=%b done=%b err=%b required all 0",
               bus.in_ready, bus.dec_load, bus.sym_valid, bus.busy, bus.done, bus.err);
    else passed++;
    checks++;
    if ({bus.dec_window, bus.sym_data, bus.sym_len} !== 14'b0)
      $display("FAIL reset_data: window=%b sym=%0d len=%0d required 0", bus.dec_window, bus.sym_data, bus.sym_len);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b00)
      $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0/0", bus.busy, bus.in_ready);
    else passed++;
  endtask

  task automatic test_basic_stream();
    words[0] = 16'hDD80; nwords = 1;
    scr_sym[0] = 4'd0; scr_len[0] = 4'd1;
    scr_sym[1] = 4'd0; scr_len[1] = 4'd1;
    scr_sym[2] = 4'd9; scr_len[2] = 4'd4;
    scr_sym[3] = 4'd3; scr_len[3] = 4'd6;
    nsym = 4; stall_idx = -1;
    do_start(16'd12);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", bus.busy);
    else passed++;
    fork
      feeder();
      run_decoder({16'hDD80, 48'h0}, 12);
    join
    check_end_ok("basic");
  endtask

  task automatic test_backpressure();
    words[0] = 16'hB5C3; words[1] = 16'h9E27; words[2] = 16'h6DFF; nwords = 3;
    for (int i = 0; i < 6; i++) begin
      scr_sym[i] = 4'(i + 1);
      scr_len[i] = 4'd6;
    end
    scr_sym[6] = 4'd7; scr_len[6] = 4'd4;
    nsym = 7; stall_idx = 2;
    do_start(16'd40);
    fork
      feeder();
      run_decoder({16'hB5C3, 16'h9E27, 16'h6DFF, 16'h0}, 40);
    join
    checks++;
    if (fed !== 3) $display("FAIL bp_words: accepted %0d required 3", fed);
    else passed++;
    check_end_ok("backpressure");
  endtask

  task automatic test_tail_pad();
    words[0] = 16'h7BFF; nwords = 1;
    scr_sym[0] = 4'd9; scr_len[0] = 4'd4;
    scr_sym[1] = 4'd2; scr_len[1] = 4'd2;
    nsym = 2; stall_idx = -1;
    do_start(16'd6);
    fork
      feeder();
      run_decoder({16'h7BFF, 48'h0}, 6);
    join
    check_end_ok("tail");
  endtask

  task automatic test_bad_len();
    int b = 0;
    int seen = 0;
    words[0] = 16'hDD80; nwords = 1;
    do_start(16'd12);
    fork
      feeder();
      begin
        while (bus.dec_load !== 1'b1 && b < 100) begin
          @(negedge clk);
          b++;
        end
        @(negedge clk);
        bus.dec_ready = 1'b1; bus.dec_symbol = 4'd1; bus.dec_len = 4'd7;
        @(negedge clk);
        bus.dec_ready = 1'b0;
        checks++;
        if ({bus.err, bus.done, bus.busy, bus.sym_valid} !== 4'b1000)
          $display("FAIL badlen_status: err=%b done=%b busy=%b sv=%b required 1/0/0/0",
                   bus.err, bus.done, bus.busy, bus.sym_valid);
        else passed++;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (bus.sym_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL badlen_no_sym: sym_valid cycles %0d required 0", seen);
        else passed++;
      end
    join
  endtask

  task automatic test_reset_mid_stream();
    int b = 0;
    words[0] = 16'hDD80; nwords = 1;
    do_start(16'd12);
    fork
      feeder();
      while (bus.dec_load !== 1'b1 && b < 100) begin
        @(negedge clk);
        b++;
      end
    join
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.dec_load, bus.sym_valid, bus.busy, bus.in_ready, bus.dec_window} !== 10'b0)
      $display("FAIL midrst_clear: load=%b sv=%b busy=%b rdy=%b win=%b required all 0",
               bus.dec_load, bus.sym_valid, bus.busy, bus.in_ready, bus.dec_window);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b1; bus.dec_symbol = 4'd5; bus.dec_len = 4'd1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    checks++;
    if ({bus.sym_valid, bus.busy} !== 2'b00)
      $display("FAIL midrst_stale: sym_valid=%b busy=%b required 0/0", bus.sym_valid, bus.busy);
    else passed++;
    words[0] = 16'h1800; nwords = 1;
    scr_sym[0] = 4'd8; scr_len[0] = 4'd6;
    nsym = 1; stall_idx = -1;
    do_start(16'd6);
    fork
      feeder();
      run_decoder({16'h1800, 48'h0}, 6);
    join
    check_end_ok("fresh");
  endtask

  task automatic test_zero_len();
    int seen = 0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hFFFF;
    do_start(16'd0);
    checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b100)
      $display("FAIL zero_done: done=%b err=%b busy=%b required 1/0/0", bus.done, bus.err, bus.busy);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      if (bus.in_ready === 1'b1) seen++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (seen !== 0) $display("FAIL zero_in_ready: ready cycles %0d required 0", seen);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.cfg_nbits = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.dec_ready = 1'b0; bus.dec_symbol = '0; bus.dec_len = '0;
    bus.sym_ready = 1'b0;
    fed = 0; nwords = 0; nsym = 0; stall_idx = -1;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_tail_pad();
    test_bad_len();
    test_reset_mid_stream();
    test_zero_len();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/huffman_stream_feeder.md
HUFFMAN_STREAM_FEEDER -- requirements
Module: huffman_stream_feeder

Interface
REQ-001 Parameter: WORD_W, default 16, width of the upstream encoded-data word.
REQ-002 Parameter: BUF_W, default 32, bit-buffer capacity; SHALL be at least 2*WORD_W.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a stream decode.
REQ-006 cfg_nbits  input  16  total encoded bits in the stream; sampled on start.
REQ-007 in_valid / in_ready  input / output  1 / 1  upstream word handshake.
REQ-008 in_data  input  WORD_W  encoded bits; MSB is first in time.
REQ-009 dec_window  output  6  MSB-aligned next 6 unconsumed bits to the decoder.
REQ-010 dec_load  output  1  one-cycle request for the decoder to sample dec_window.
REQ-011 dec_ready  input  1  decoder pulse; dec_symbol and dec_len are valid this cycle.
REQ-012 dec_symbol / dec_len  input / input  4 / 4  decoded symbol and its code length in bits.
REQ-013 sym_valid / sym_ready  output / input  1 / 1  downstream symbol handshake.
REQ-014 sym_data / sym_len  output / output  4 / 4  decoded symbol and its length.
REQ-015 busy / done / err  output  1 each  busy = stream active; done and err are sticky until the next start.

Function
REQ-016 Bit buffer: BUF_W bits plus count `cnt`; in_data is appended below the existing valid bits, MSB first.
REQ-017 in_ready SHALL be 1 only while busy, cnt <= BUF_W-WORD_W, and fetched bits < cfg_nbits; a word is accepted when in_valid && in_ready.
REQ-018 Fetched-bit counter `fetched` SHALL increase by WORD_W per accepted word; bits beyond cfg_nbits in the final word are ignored for consumption.
REQ-019 State machine states: IDLE, FILL, LOAD, WAIT, EMIT, DONE.
REQ-020 IDLE: on start, clear the buffer, latch cfg_nbits into `remain`, and go to FILL; if cfg_nbits==0, go directly to DONE with done=1.
REQ-021 FILL -> LOAD when cnt >= 6, or when fetched >= cfg_nbits and cnt > 0.
REQ-022 LOAD: drive dec_window = top 6 valid bits, with missing low bits zero-padded; assert dec_load for exactly 1 cycle; go to WAIT.
REQ-023 WAIT: hold dec_window stable; on dec_ready, capture dec_symbol and dec_len and go to EMIT.
REQ-024 In WAIT, dec_len==0, dec_len>6, or dec_len>remain SHALL set err=1 and go to DONE without consuming bits.
REQ-025 EMIT: hold sym_valid=1 until sym_ready; on handshake, shift dec_len bits out of the buffer, cnt -= dec_len, remain -= dec_len.
REQ-026 From EMIT: go to DONE with done=1 if remain reaches 0; otherwise go to FILL.
REQ-027 Latency: LOAD -> dec_load is 1 cycle; dec_ready -> sym_valid is 1 cycle; handshake -> next dec_load is no less than 2 cycles when the buffer holds 6 or more bits.
REQ-028 Upstream words SHALL be accepted in any state except IDLE and DONE, including the cycle bits are consumed; same-cycle append and consume SHALL both apply, using the pre-shift cnt for placement.
REQ-029 busy=1 in FILL, LOAD, WAIT, and EMIT.
REQ-030 start while busy SHALL be ignored.
REQ-031 DONE: stay until start; start behaves as in IDLE.
REQ-032 Output registers: dec_load and sym_valid SHALL be registered; dec_ready asserted outside WAIT SHALL be ignored.

Reset
REQ-033 On rst low: state=IDLE, cnt=0, fetched=0, remain=0, in_ready=0, dec_load=0, dec_window=0, sym_valid=0, sym_data=0, sym_len=0, busy=0, done=0, err=0.
REQ-034 Reset mid-stream SHALL abandon the stream immediately with no further dec_load or sym_valid; buffered bits are discarded.

Verification
REQ-035 Stream "1 1 0111 011000" (12 bits, one 16-bit word 0xDD80, cfg_nbits=12), with a decoder model -> symbols 0,0,9,3 with lengths 1,1,4,6; then done=1 and err=0.
REQ-036 cfg_nbits=40 over 3 words, with sym_ready held low for 5 cycles during one EMIT -> sym_valid holds, no dec_load is issued, and no word is lost.
REQ-037 Final 2 bits "10" remaining -> dec_window=6'b100000, and decoding completes with remain=0.
REQ-038 Decoder returns dec_len=7 -> err=1, done=0, busy=0, and no sym_valid.
REQ-039 rst asserted during WAIT, then start with cfg_nbits=6 and word 0x1800 -> the fresh decode yields symbol 8 with length 6, and no stale symbol appears.
REQ-040 start with cfg_nbits=0 -> done=1 the next cycle, and in_ready stays 0.
